seq_datapath: RTL and testbench

SEQ_DATAPATH -- requirements
Module: seq_datapath

---
 rtl/seq_datapath.sv | 107 ++++++++++
 tb/tb_seq_datapath.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/seq_datapath.sv
// Add/subtract datapath slaved to an upstream 4-phase sequencer (start0, start1, start2, finish).
// Operands are captured in start1, the sum/difference is formed in start2 and published at finish.
module seq_datapath #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [1:0]       q,
   input  logic             mode,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] result,
   output logic             cflag,
   output logic             done,
   output logic             busy,
   output logic             seq_err,
   output logic [7:0]       op_count
);

   typedef enum logic [1:0] {
      st_start0 = 2'b00,
      st_start1 = 2'b01,
      st_start2 = 2'b10,
      st_finish = 2'b11
   } seq_state_t;

   seq_state_t       cur_q;
   seq_state_t       prev_q;
   logic             abort;
   logic             legal;
   logic             finish;
   logic [WIDTH-1:0] a_r;
   logic [WIDTH-1:0] b_r;
   logic             mode_r;
   logic [WIDTH:0]   acc;

   assign cur_q = seq_state_t'(q);

   // Legal sequencer steps; start0 may idle in place, everything else must advance.
   // A finish only publishes if this step is legal and no earlier violation is pending.
   always_comb begin
      legal = 1'b0;
      case (prev_q)
         st_start0: legal = (cur_q == st_start0) || (cur_q == st_start1);
         st_start1: legal = (cur_q == st_start2);
         st_start2: legal = (cur_q == st_finish);
         st_finish: legal = (cur_q == st_start0);
         default:   legal = 1'b0;
      endcase
      finish = (cur_q == st_finish) && legal && !abort;
   end

   // Sequence tracking: error is sticky until reset, abort lasts until the sequencer returns to start0.
   always_ff @(posedge clk) begin
      if (rst) begin
         prev_q  <= st_start0;
         seq_err <= 1'b0;
         abort   <= 1'b0;
      end else begin
         prev_q <= cur_q;
         if (!legal) seq_err <= 1'b1;
         if (cur_q == st_start0) abort <= 1'b0;
         else if (!legal)        abort <= 1'b1;
      end
   end

   // Operand capture and arithmetic; acc[WIDTH] is carry for add and borrow for subtract.
   always_ff @(posedge clk) begin
      if (rst) begin
         a_r    <= '0;
         b_r    <= '0;
         mode_r <= 1'b0;
         acc    <= '0;
      end else begin
         if (cur_q == st_start1) begin
            a_r    <= a;
            b_r    <= b;
            mode_r <= mode;
         end
         if (cur_q == st_start2)
            acc <= mode_r ? ({1'b0, a_r} + {1'b0, b_r}) : ({1'b0, a_r} - {1'b0, b_r});
      end
   end

   // Published results and status; an aborted pass leaves result, cflag and op_count untouched.
   always_ff @(posedge clk) begin
      if (rst) begin
         result   <= '0;
         cflag    <= 1'b0;
         done     <= 1'b0;
         busy     <= 1'b0;
         op_count <= 8'd0;
      end else begin
         done <= finish;
         if (finish) begin
            result   <= acc[WIDTH-1:0];
            cflag    <= acc[WIDTH];
            op_count <= op_count + 8'd1;
         end
         if (cur_q == st_start1)
            busy <= 1'b1;
         else if ((cur_q == st_finish) || (cur_q == st_start0))
            busy <= 1'b0;
      end
   end

endmodule

// File: tb/tb_seq_datapath.sv
// Self-checking bench for seq_datapath: directed passes plus randomized sequencer traffic,
// all outputs compared every cycle against a behavioural model of the pass rules.
module tb_seq_datapath;

   localparam int WIDTH = 8;

   logic             clk = 1'b0;
   logic             rst;
   logic [1:0]       q;
   logic             mode;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [WIDTH-1:0] result;
   logic             cflag;
   logic             done;
   logic             busy;
   logic             seqErr;
   logic [7:0]       opCount;

   int checks    = 0;
   int errors    = 0;
   int doneSeen  = 0;
   bit compareOn = 1'b0;

   int mResult = 0, mOpCount = 0, mPrev = 0, mA = 0, mB = 0, mAccRes = 0;
   bit mCflag = 0, mDone = 0, mBusy = 0, mSeqErr = 0, mAbort = 0, mMode = 0, mAccC = 0;

   always #5 clk = ~clk;

   seq_datapath #(.WIDTH(WIDTH)) dut (
      .clk      (clk),
      .rst      (rst),
      .q        (q),
      .mode     (mode),
      .a        (a),
      .b        (b),
      .result   (result),
      .cflag    (cflag),
      .done     (done),
      .busy     (busy),
      .seq_err  (seqErr),
      .op_count (opCount)
   );

   task automatic checkOutput(input string name, input int actual, input int expected);
      checks++;
      if (actual != expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d at time %0t", name, actual, expected, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic [1:0] qv, input logic [7:0] av, input logic [7:0] bv, input logic mv);
      q    = qv;
      a    = av;
      b    = bv;
      mode = mv;
      tick();
   endtask

   // Drives start1, start2, finish; returns just after the finish edge.
   task automatic runPass(input logic [7:0] av, input logic [7:0] bv, input logic mv, input bit toggle);
      applyStimulus(2'b01, av, bv, mv);
      applyStimulus(2'b10, $urandom_range(0, 255), $urandom_range(0, 255), toggle ? ~mv : mv);
      applyStimulus(2'b11, $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 1));
   endtask

   // Behavioural model: what each pass must publish, from the sequencing and arithmetic rules.
   always @(posedge clk) begin : model
      bit legal;
      bit fin;
      int sum;
      if (rst) begin
         mResult = 0; mCflag = 0; mDone = 0; mBusy = 0; mSeqErr = 0; mOpCount = 0;
         mPrev = 0; mAbort = 0; mA = 0; mB = 0; mMode = 0; mAccRes = 0; mAccC = 0;
      end else begin
         legal = (mPrev == 0 && q <= 2'd1) || (mPrev == 1 && q == 2'd2) ||
                 (mPrev == 2 && q == 2'd3) || (mPrev == 3 && q == 2'd0);
         fin   = (q == 2'd3) && legal && !mAbort;
         if (!legal) mSeqErr = 1;
         if (q == 2'd0)   mAbort = 0;
         else if (!legal) mAbort = 1;
         mDone = fin;
         if (fin) begin
            mResult  = mAccRes;
            mCflag   = mAccC;
            mOpCount = (mOpCount + 1) % 256;
         end
         if (q == 2'd2) begin
            if (mMode) begin
               sum     = mA + mB;
               mAccRes = sum % 256;
               mAccC   = (sum > 255);
            end else begin
               mAccRes = (mA - mB + 256) % 256;
               mAccC   = (mA < mB);
            end
         end
         if (q == 2'd1) begin
            mA    = a;
            mB    = b;
            mMode = mode;
            mBusy = 1;
         end else if (q == 2'd3 || q == 2'd0) begin
            mBusy = 0;
         end
         mPrev = q;
      end
   end

   // Every-cycle comparison of all outputs against the model.
   always @(negedge clk) begin
      if (compareOn) begin
         checkOutput("result",   result,  mResult);
         checkOutput("cflag",    cflag,   mCflag);
         checkOutput("done",     done,    mDone);
         checkOutput("busy",     busy,    mBusy);
         checkOutput("seq_err",  seqErr,  mSeqErr);
         checkOutput("op_count", opCount, mOpCount);
         if (done) doneSeen++;
      end
   end

   initial begin
      logic [1:0] curQ;
      logic [1:0] nextQ;

      rst = 1'b1; q = 2'b00; a = '0; b = '0; mode = 1'b0;
      tick();
      tick();
      compareOn = 1'b1;
      rst = 1'b0;
      $display("[TB] reset and idle");
      for (int i = 0; i < 3; i++) applyStimulus(2'b00, 8'd0, 8'd0, 1'b0);
      checkOutput("idle_result",   result,   0);
      checkOutput("idle_busy",     busy,     0);
      checkOutput("idle_op_count", opCount,  0);
      checkOutput("idle_done_cnt", doneSeen, 0);

      $display("[TB] add 200+100");
      runPass(8'd200, 8'd100, 1'b1, 1'b0);
      checkOutput("add_result",   result,  44);
      checkOutput("add_cflag",    cflag,   1);
      checkOutput("add_done",     done,    1);
      checkOutput("add_op_count", opCount, 1);
      applyStimulus(2'b00, 8'd0, 8'd0, 1'b0);
      checkOutput("add_done_off", done, 0);

      $display("[TB] subtract 5-9 with mode toggled in start2");
      runPass(8'd5, 8'd9, 1'b0, 1'b1);
      checkOutput("sub_result",   result,  252);
      checkOutput("sub_cflag",    cflag,   1);
      checkOutput("sub_op_count", opCount, 2);
      applyStimulus(2'b00, 8'd0, 8'd0, 1'b0);

      $display("[TB] illegal skip start1 to finish");
      applyStimulus(2'b01, 8'd1, 8'd1, 1'b1);
      applyStimulus(2'b11, 8'd0, 8'd0, 1'b0);
      checkOutput("ill_seq_err",  seqErr,  1);
      checkOutput("ill_done",     done,    0);
      checkOutput("ill_result",   result,  252);
      checkOutput("ill_op_count", opCount, 2);
      applyStimulus(2'b00, 8'd0, 8'd0, 1'b0);
      runPass(8'd7, 8'd3, 1'b1, 1'b0);
      checkOutput("rec_done",     done,    1);
      checkOutput("rec_result",   result,  10);
      checkOutput("rec_cflag",    cflag,   0);
      checkOutput("rec_op_count", opCount, 3);
      applyStimulus(2'b00, 8'd0, 8'd0, 1'b0);

      $display("[TB] 256 passes for op_count wrap");
      rst = 1'b1;
      tick();
      rst = 1'b0;
      applyStimulus(2'b00, 8'd0, 8'd0, 1'b0);
      doneSeen = 0;
      for (int i = 0; i < 256; i++) begin
         runPass($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 1), 1'b0);
         applyStimulus(2'b00, 8'd0, 8'd0, 1'b0);
      end
      checkOutput("wrap_op_count", opCount,  0);
      checkOutput("wrap_done_cnt", doneSeen, 256);

      $display("[TB] reset during start2");
      applyStimulus(2'b01, 8'd90, 8'd20, 1'b1);
      rst = 1'b1;
      applyStimulus(2'b10, 8'd0, 8'd0, 1'b0);
      rst = 1'b0;
      checkOutput("rst_result",   result,  0);
      checkOutput("rst_busy",     busy,    0);
      checkOutput("rst_seq_err",  seqErr,  0);
      checkOutput("rst_op_count", opCount, 0);
      applyStimulus(2'b00, 8'd0, 8'd0, 1'b0);
      checkOutput("rst_done", done, 0);
      runPass(8'd50, 8'd60, 1'b1, 1'b0);
      checkOutput("post_rst_result",   result,  110);
      checkOutput("post_rst_cflag",    cflag,   0);
      checkOutput("post_rst_op_count", opCount, 1);
      applyStimulus(2'b00, 8'd0, 8'd0, 1'b0);

      $display("[TB] randomized sequencer traffic");
      curQ = 2'b00;
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 9) == 0) nextQ = 2'($urandom_range(0, 3));
         else begin
            case (curQ)
               2'b00:   nextQ = 2'($urandom_range(0, 1));
               2'b01:   nextQ = 2'b10;
               2'b10:   nextQ = 2'b11;
               default: nextQ = 2'b00;
            endcase
         end
         rst = ($urandom_range(0, 49) == 0);
         applyStimulus(nextQ, $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 1));
         curQ = rst ? 2'b00 : nextQ;
      end
      rst = 1'b0;
      applyStimulus(2'b00, 8'd0, 8'd0, 1'b0);
      tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
